cdb_arbiter: RTL and testbench

// - Shares N_CDB result-broadcast buses (PRF write + wakeup + ROB completion) among N_SRC execution units.
// - Sits between the ADD/MUL/DIV unit outputs and the PRF/ROB write ports.
// - Buffers each unit's results in a small FIFO and grants up to N_CDB heads per cycle onto registered bus outputs.

---
 rtl/back_end_pkg.sv | 32 +++
 rtl/wb_skid_fifo.sv | 87 ++++++++
 rtl/cdb_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/back_end_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : back_end_pkg
//  Description : Shared back-end types for the result broadcast path. Holds
//                the width constants and the entry carried on a CDB bus.
//  Revision    : 1.0 - initial release
// ============================================================================
package back_end_pkg;

    localparam int W_DATA = 16;   // result width
    localparam int W_P    = 5;    // physical register tag width
    localparam int W_TAG  = 5;    // ROB tag width

    // One completed result as buffered per source and driven on a bus.
    typedef struct packed {
        logic [W_P-1:0]    Pw;
        logic [W_DATA-1:0] result;
        logic              exp;
        logic [W_TAG-1:0]  tag_ROB;
    } cdb_entry_t;

    // Distance of a ROB tag from the ROB head; wraps with the tag space so
    // the oldest in-flight instruction always has the smallest age.
    function automatic logic [W_TAG-1:0] rob_age(
        input logic [W_TAG-1:0] tag,
        input logic [W_TAG-1:0] head
    );
        return tag - head;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_skid_fifo
//  Description : Small per-source result FIFO in front of the CDB arbiter.
//                Full is derived from the registered count only, so a full
//                FIFO refuses a push even when it pops in the same cycle.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk      in   clock
//    rst      in   synchronous active-high reset (empties the FIFO)
//    i_flush  in   empties the FIFO, drops a same-cycle push
//    i_push   in   write request (ignored while full)
//    i_entry  in   entry to write
//    i_pop    in   remove head (ignored while empty)
//    o_head   out  oldest entry
//    o_empty  out  no entries held
//    o_full   out  DEPTH entries held
// ============================================================================
module wb_skid_fifo
    import back_end_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_flush,
    input  logic       i_push,
    input  cdb_entry_t i_entry,
    input  logic       i_pop,
    output cdb_entry_t o_head,
    output logic       o_empty,
    output logic       o_full
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DEPTH);

    cdb_entry_t         r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_last) ? '0 : p + c_ptr_w'(1);
    endfunction

    assign o_full    = (r_count == c_cnt_full);
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push & ~o_full & ~i_flush;
    assign w_pop_ok  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            // A simultaneous push and pop leaves the count unchanged.
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: only slots behind a valid count are ever read.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter
//  Description : Shares N_CDB registered result-broadcast buses among N_SRC
//                execution units. Each unit feeds a wb_skid_fifo; up to N_CDB
//                non-empty heads are granted per cycle, grant k driving bus k.
//                Default arbitration is round-robin from rr_ptr. Defining
//                CDB_AGE_PRIO_EN switches to oldest-ROB-age-first priority
//                (ties to the lower source index) and uses rob_head.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rst      clock, synchronous active-high reset
//    flush         empties FIFOs, clears bus valids, rr_ptr to 0
//    freeze_back   holds grants, pops, rr_ptr and bus outputs
//    src_*         per-source result inputs, src_ready = FIFO not full
//    rob_head      ROB head tag (age priority build only)
//    *_cdb         registered bus outputs, one slice per bus
// ============================================================================
module cdb_arbiter
    import back_end_pkg::*;
#(
    parameter int N_SRC      = 3,
    parameter int N_CDB      = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    freeze_back,
    input  logic [N_SRC-1:0]        src_valid,
    output logic [N_SRC-1:0]        src_ready,
    input  logic [N_SRC*W_P-1:0]    src_Pw,
    input  logic [N_SRC*W_DATA-1:0] src_result,
    input  logic [N_SRC-1:0]        src_exp,
    input  logic [N_SRC*W_TAG-1:0]  src_tag_ROB,
    input  logic [W_TAG-1:0]        rob_head,
    output logic [N_CDB-1:0]        valid_cdb,
    output logic [N_CDB*W_P-1:0]    Pw_cdb,
    output logic [N_CDB*W_DATA-1:0] Result_cdb,
    output logic [N_CDB-1:0]        exp_cdb,
    output logic [N_CDB*W_TAG-1:0]  tag_ROB_cdb
);

    localparam int c_idx_w = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    cdb_entry_t         w_head [N_SRC];
    logic [N_SRC-1:0]   w_empty;
    logic [N_SRC-1:0]   w_full;
    logic [N_SRC-1:0]   w_pop;
    logic               w_arb_en;
    logic [N_CDB-1:0]   w_gnt_vld;
    cdb_entry_t         w_gnt_entry [N_CDB];
    logic [c_idx_w-1:0] w_rr_next;

    logic [c_idx_w-1:0] r_rr_ptr;
    logic [N_CDB-1:0]   r_valid;
    cdb_entry_t         r_bus [N_CDB];

    // ------------------------------------------------------------------
    // Per-source FIFOs
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < N_SRC; g++) begin : g_src
            cdb_entry_t w_in;

            assign w_in.Pw      = src_Pw[g*W_P +: W_P];
            assign w_in.result  = src_result[g*W_DATA +: W_DATA];
            assign w_in.exp     = src_exp[g];
            assign w_in.tag_ROB = src_tag_ROB[g*W_TAG +: W_TAG];

            wb_skid_fifo #(
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .i_flush (flush),
                .i_push  (src_valid[g]),
                .i_entry (w_in),
                .i_pop   (w_pop[g]),
                .o_head  (w_head[g]),
                .o_empty (w_empty[g]),
                .o_full  (w_full[g])
            );

            assign src_ready[g] = ~w_full[g];
        end
    endgenerate

    // Flush wins over freeze; either one suppresses all grants and pops.
    assign w_arb_en = ~freeze_back & ~flush;

    // ------------------------------------------------------------------
    // Arbitration over FIFO heads
    // ------------------------------------------------------------------
`ifdef CDB_AGE_PRIO_EN
    always_comb begin
        logic [N_SRC-1:0] taken;
        logic             found;
        int               best;
        logic [W_TAG-1:0] best_age;
        logic [W_TAG-1:0] age;

        w_gnt_vld = '0;
        w_pop     = '0;
        w_rr_next = r_rr_ptr;
        for (int k = 0; k < N_CDB; k++) begin
            w_gnt_entry[k] = '0;
        end
        taken    = '0;
        found    = 1'b0;
        best     = 0;
        best_age = '0;
        age      = '0;

        if (w_arb_en) begin
            // Bus k gets the k-th oldest head; strict '<' over ascending
            // source index resolves equal ages toward the lower index.
            for (int k = 0; k < N_CDB; k++) begin
                found    = 1'b0;
                best     = 0;
                best_age = '0;
                for (int s = 0; s < N_SRC; s++) begin
                    age = rob_age(w_head[s].tag_ROB, rob_head);
                    if (!w_empty[s] && !taken[s] && (!found || age < best_age)) begin
                        found    = 1'b1;
                        best     = s;
                        best_age = age;
                    end
                end
                for (int s = 0; s < N_SRC; s++) begin
                    if (found && s == best) begin
                        taken[s]       = 1'b1;
                        w_pop[s]       = 1'b1;
                        w_gnt_vld[k]   = 1'b1;
                        w_gnt_entry[k] = w_head[s];
                    end
                end
            end
        end
        // The round-robin pointer has no role under age priority.
        w_rr_next = '0;
    end
`else
    always_comb begin
        int cnt;
        int pos;
        int last;

        w_gnt_vld = '0;
        w_pop     = '0;
        w_rr_next = r_rr_ptr;
        for (int k = 0; k < N_CDB; k++) begin
            w_gnt_entry[k] = '0;
        end
        cnt  = 0;
        pos  = 0;
        last = 0;

        if (w_arb_en) begin
            // Walk sources in scan order from rr_ptr; the n-th non-empty
            // head found is assigned to bus n until the buses run out.
            for (int i = 0; i < N_SRC; i++) begin
                pos = (int'(r_rr_ptr) + i) % N_SRC;
                for (int s = 0; s < N_SRC; s++) begin
                    if (s == pos && !w_empty[s] && cnt < N_CDB) begin
                        for (int k = 0; k < N_CDB; k++) begin
                            if (k == cnt) begin
                                w_gnt_vld[k]   = 1'b1;
                                w_gnt_entry[k] = w_head[s];
                            end
                        end
                        w_pop[s] = 1'b1;
                        last     = s;
                        cnt      = cnt + 1;
                    end
                end
            end
            if (cnt != 0) begin
                w_rr_next = c_idx_w'((last + 1) % N_SRC);
            end
        end
    end

    // rob_head only matters for age priority.
    logic w_unused_rob_head;
    assign w_unused_rob_head = ^rob_head;
`endif

    // ------------------------------------------------------------------
    // Registered bus outputs and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= '0;
            r_rr_ptr <= '0;
            for (int k = 0; k < N_CDB; k++) begin
                r_bus[k] <= '0;
            end
        end else if (flush) begin
            // Data fields are left as they were; only valid is cleared.
            r_valid  <= '0;
            r_rr_ptr <= '0;
        end else if (!freeze_back) begin
            r_valid  <= w_gnt_vld;
            r_rr_ptr <= w_rr_next;
            for (int k = 0; k < N_CDB; k++) begin
                if (w_gnt_vld[k]) begin
                    r_bus[k] <= w_gnt_entry[k];
                end
            end
        end
    end

    assign valid_cdb = r_valid;

    generate
        for (genvar k = 0; k < N_CDB; k++) begin : g_cdb
            assign Pw_cdb[k*W_P +: W_P]          = r_bus[k].Pw;
            assign Result_cdb[k*W_DATA +: W_DATA] = r_bus[k].result;
            assign exp_cdb[k]                    = r_bus[k].exp;
            assign tag_ROB_cdb[k*W_TAG +: W_TAG]  = r_bus[k].tag_ROB;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdb_arbiter
//  Description : Self-checking bench for cdb_arbiter. Directed scenarios plus
//                randomized traffic compared against a queue-based model of
//                the broadcast rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;
    import back_end_pkg::*;

    localparam int N_SRC = 3;
    localparam int N_CDB = 2;
    localparam int DEPTH = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush;
    logic                    freeze_back;
    logic [N_SRC-1:0]        src_valid;
    logic [N_SRC-1:0]        src_ready;
    logic [N_SRC*W_P-1:0]    src_Pw;
    logic [N_SRC*W_DATA-1:0] src_result;
    logic [N_SRC-1:0]        src_exp;
    logic [N_SRC*W_TAG-1:0]  src_tag_ROB;
    logic [W_TAG-1:0]        rob_head;
    logic [N_CDB-1:0]        valid_cdb;
    logic [N_CDB*W_P-1:0]    Pw_cdb;
    logic [N_CDB*W_DATA-1:0] Result_cdb;
    logic [N_CDB-1:0]        exp_cdb;
    logic [N_CDB*W_TAG-1:0]  tag_ROB_cdb;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    cdb_entry_t       m_q [N_SRC][$];
    logic [N_CDB-1:0] m_valid;
    cdb_entry_t       m_bus [N_CDB];
    int               m_rr;

    always #5 clk = ~clk;

    cdb_arbiter #(
        .N_SRC      (N_SRC),
        .N_CDB      (N_CDB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .freeze_back (freeze_back),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_Pw      (src_Pw),
        .src_result  (src_result),
        .src_exp     (src_exp),
        .src_tag_ROB (src_tag_ROB),
        .rob_head    (rob_head),
        .valid_cdb   (valid_cdb),
        .Pw_cdb      (Pw_cdb),
        .Result_cdb  (Result_cdb),
        .exp_cdb     (exp_cdb),
        .tag_ROB_cdb (tag_ROB_cdb)
    );

    // ---------------- helpers ----------------
    function automatic cdb_entry_t mk(int s, int seq);
        cdb_entry_t e;
        e.Pw      = W_P'(s * 8 + seq);
        e.result  = W_DATA'(32'hA000 + s * 256 + seq * 17);
        e.exp     = seq[0];
        e.tag_ROB = W_TAG'(s * 8 + seq);
        return e;
    endfunction

    function automatic cdb_entry_t in_entry(int s);
        cdb_entry_t e;
        e.Pw      = src_Pw[s*W_P +: W_P];
        e.result  = src_result[s*W_DATA +: W_DATA];
        e.exp     = src_exp[s];
        e.tag_ROB = src_tag_ROB[s*W_TAG +: W_TAG];
        return e;
    endfunction

    function automatic cdb_entry_t bus_entry(int k);
        cdb_entry_t e;
        e.Pw      = Pw_cdb[k*W_P +: W_P];
        e.result  = Result_cdb[k*W_DATA +: W_DATA];
        e.exp     = exp_cdb[k];
        e.tag_ROB = tag_ROB_cdb[k*W_TAG +: W_TAG];
        return e;
    endfunction

    task automatic set_src(int s, cdb_entry_t e);
        src_valid[s]                   = 1'b1;
        src_Pw[s*W_P +: W_P]           = e.Pw;
        src_result[s*W_DATA +: W_DATA] = e.result;
        src_exp[s]                     = e.exp;
        src_tag_ROB[s*W_TAG +: W_TAG]  = e.tag_ROB;
    endtask

    function automatic int age_of(cdb_entry_t e);
        return (int'(e.tag_ROB) - int'(rob_head) + 32) % 32;
    endfunction

    function automatic logic [N_SRC-1:0] model_ready();
        logic [N_SRC-1:0] r;
        for (int s = 0; s < N_SRC; s++) r[s] = (m_q[s].size() < DEPTH);
        return r;
    endfunction

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic [N_SRC-1:0] rdy;
        int order[$];
        bit used [N_SRC];
        int best;
        int last;
        rdy = model_ready();
        if (rst || flush) begin
            for (int s = 0; s < N_SRC; s++) m_q[s].delete();
            m_valid = '0;
            m_rr    = 0;
            if (rst) for (int k = 0; k < N_CDB; k++) m_bus[k] = '0;
        end else begin
            if (!freeze_back) begin
`ifdef CDB_AGE_PRIO_EN
                for (int s = 0; s < N_SRC; s++) used[s] = 0;
                for (int k = 0; k < N_SRC; k++) begin
                    best = -1;
                    for (int s = 0; s < N_SRC; s++)
                        if (m_q[s].size() > 0 && !used[s] &&
                            (best < 0 || age_of(m_q[s][0]) < age_of(m_q[best][0])))
                            best = s;
                    if (best >= 0) begin
                        used[best] = 1;
                        order.push_back(best);
                    end
                end
`else
                for (int i = 0; i < N_SRC; i++)
                    if (m_q[(m_rr + i) % N_SRC].size() > 0) order.push_back((m_rr + i) % N_SRC);
`endif
                m_valid = '0;
                last    = -1;
                for (int k = 0; k < N_CDB && k < order.size(); k++) begin
                    m_valid[k] = 1'b1;
                    m_bus[k]   = m_q[order[k]].pop_front();
                    last       = order[k];
                end
`ifndef CDB_AGE_PRIO_EN
                if (last >= 0) m_rr = (last + 1) % N_SRC;
`endif
            end
            for (int s = 0; s < N_SRC; s++)
                if (src_valid[s] && rdy[s]) m_q[s].push_back(in_entry(s));
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (valid_cdb !== 2'b00) begin failures++; $display("FAIL reset_valid got=%b exp=00", valid_cdb); end
        checks++;
        if ({Pw_cdb, Result_cdb, exp_cdb, tag_ROB_cdb} !== '0) begin
            failures++; $display("FAIL reset_data got=%h/%h/%b/%h exp=0", Pw_cdb, Result_cdb, exp_cdb, tag_ROB_cdb);
        end
        checks++;
        if (src_ready !== 3'b111) begin failures++; $display("FAIL reset_ready got=%b exp=111", src_ready); end
        rst = 1'b0;
        tick();
        checks++;
        if (valid_cdb !== 2'b00) begin failures++; $display("FAIL reset_idle_valid got=%b exp=00", valid_cdb); end
    endtask

    task automatic test_single_push();
        cdb_entry_t e;
        e.Pw = 5'd3; e.result = 16'h1234; e.exp = 1'b0; e.tag_ROB = 5'd7;
        set_src(0, e);
        tick();
        src_valid = '0;
        checks++;
        if (valid_cdb !== 2'b00) begin failures++; $display("FAIL single_early got=%b exp=00", valid_cdb); end
        tick();
        checks++;
        if (valid_cdb !== 2'b01) begin failures++; $display("FAIL single_valid got=%b exp=01", valid_cdb); end
        checks++;
        if (Pw_cdb[4:0] !== 5'd3 || Result_cdb[15:0] !== 16'h1234 || tag_ROB_cdb[4:0] !== 5'd7) begin
            failures++; $display("FAIL single_fields got=%h/%h/%h exp=03/1234/07", Pw_cdb[4:0], Result_cdb[15:0], tag_ROB_cdb[4:0]);
        end
        tick();
        checks++;
        if (valid_cdb !== 2'b00) begin failures++; $display("FAIL single_after got=%b exp=00", valid_cdb); end
    endtask

    task automatic test_three_sources();
        pulse_flush();
        for (int s = 0; s < N_SRC; s++) set_src(s, mk(s, 0));
        tick();
        src_valid = '0;
        tick();
        checks++;
        if (valid_cdb !== 2'b11) begin failures++; $display("FAIL three_valid1 got=%b exp=11", valid_cdb); end
        checks++;
        if (bus_entry(0) !== mk(0, 0) || bus_entry(1) !== mk(1, 0)) begin
            failures++; $display("FAIL three_buses1 got=%h,%h exp=%h,%h", bus_entry(0), bus_entry(1), mk(0, 0), mk(1, 0));
        end
        tick();
        checks++;
        if (valid_cdb !== 2'b01 || bus_entry(0) !== mk(2, 0)) begin
            failures++; $display("FAIL three_bus2 got=%b/%h exp=01/%h", valid_cdb, bus_entry(0), mk(2, 0));
        end
        tick();
        checks++;
        if (valid_cdb !== 2'b00) begin failures++; $display("FAIL three_idle got=%b exp=00", valid_cdb); end
    endtask

    task automatic test_age();
        cdb_entry_t e;
        pulse_flush();
        rob_head = 5'd30;
        e = mk(0, 0); e.tag_ROB = 5'd2;  set_src(0, e);
        e = mk(1, 0); e.tag_ROB = 5'd31; set_src(1, e);
        e = mk(2, 0); e.tag_ROB = 5'd0;  set_src(2, e);
        tick();
        src_valid = '0;
        tick();
        checks++;
        if (valid_cdb !== 2'b11 || tag_ROB_cdb !== {5'd0, 5'd31}) begin
            failures++; $display("FAIL age_first got=%b/%h exp=11/%h", valid_cdb, tag_ROB_cdb, {5'd0, 5'd31});
        end
        tick();
        checks++;
        if (valid_cdb !== 2'b01 || tag_ROB_cdb[4:0] !== 5'd2) begin
            failures++; $display("FAIL age_second got=%b/%h exp=01/02", valid_cdb, tag_ROB_cdb[4:0]);
        end
    endtask

    task automatic test_back_to_back();
        cdb_entry_t seen[$];
        int pushed;
        logic acc;
        pulse_flush();
        tick();
        freeze_back = 1'b1;
        pushed = 0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (src_ready[1] !== 1'b1) begin failures++; $display("FAIL b2b_ready_low_early got=%b exp=1 count=%0d", src_ready[1], c); end
            set_src(1, mk(1, pushed));
            tick();
            pushed++;
        end
        checks++;
        if (src_ready[1] !== 1'b0) begin failures++; $display("FAIL b2b_ready_full got=%b exp=0", src_ready[1]); end
        freeze_back = 1'b0;
        for (int c = 0; c < 40 && seen.size() < 4; c++) begin
            if (pushed < 4) set_src(1, mk(1, pushed));
            else src_valid[1] = 1'b0;
            acc = src_valid[1] & src_ready[1];
            tick();
            if (acc) pushed++;
            for (int k = 0; k < N_CDB; k++) if (valid_cdb[k]) seen.push_back(bus_entry(k));
        end
        src_valid = '0;
        checks++;
        if (seen.size() != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", seen.size()); end
        for (int i = 0; i < seen.size() && i < 4; i++) begin
            checks++;
            if (seen[i] !== mk(1, i)) begin failures++; $display("FAIL b2b_order idx=%0d got=%h exp=%h", i, seen[i], mk(1, i)); end
        end
    endtask

    task automatic test_freeze();
        cdb_entry_t exp_q [N_SRC][$];
        cdb_entry_t got_q [N_SRC][$];
        cdb_entry_t e;
        int nxt [N_SRC];
        logic [N_SRC-1:0] acc;
        pulse_flush();
        set_src(0, mk(0, 5));
        tick();
        set_src(0, mk(0, 6));
        tick();
        src_valid = '0;
        exp_q[0].push_back(mk(0, 6));
        for (int s = 0; s < N_SRC; s++) nxt[s] = 0;
        freeze_back = 1'b1;
        for (int c = 0; c < 3; c++) begin
            for (int s = 0; s < N_SRC; s++) set_src(s, mk(s, nxt[s]));
            acc = src_ready;
            tick();
            for (int s = 0; s < N_SRC; s++) if (acc[s]) begin exp_q[s].push_back(mk(s, nxt[s])); nxt[s]++; end
            checks++;
            if (valid_cdb !== 2'b01 || bus_entry(0) !== mk(0, 5)) begin
                failures++; $display("FAIL freeze_hold cyc=%0d got=%b/%h exp=01/%h", c, valid_cdb, bus_entry(0), mk(0, 5));
            end
        end
        checks++;
        if (src_ready !== 3'b000) begin failures++; $display("FAIL freeze_full got=%b exp=000", src_ready); end
        src_valid   = '0;
        freeze_back = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            for (int k = 0; k < N_CDB; k++)
                if (valid_cdb[k]) begin
                    e = bus_entry(k);
                    if (e.tag_ROB / 8 < N_SRC) got_q[e.tag_ROB / 8].push_back(e);
                end
        end
        for (int s = 0; s < N_SRC; s++) begin
            checks++;
            if (got_q[s] != exp_q[s]) begin
                failures++; $display("FAIL freeze_drain src=%0d got_n=%0d exp_n=%0d", s, got_q[s].size(), exp_q[s].size());
            end
        end
    endtask

    task automatic test_flush();
        pulse_flush();
        freeze_back = 1'b1;
        for (int c = 0; c < 2; c++) begin
            for (int s = 0; s < N_SRC; s++) set_src(s, mk(s, c));
            tick();
        end
        freeze_back = 1'b0;
        flush = 1'b1;
        for (int s = 0; s < N_SRC; s++) set_src(s, mk(s, 2));
        tick();
        flush     = 1'b0;
        src_valid = '0;
        checks++;
        if (valid_cdb !== 2'b00) begin failures++; $display("FAIL flush_valid got=%b exp=00", valid_cdb); end
        checks++;
        if (src_ready !== 3'b111) begin failures++; $display("FAIL flush_ready got=%b exp=111", src_ready); end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (valid_cdb !== 2'b00) begin failures++; $display("FAIL flush_quiet cyc=%0d got=%b exp=00", c, valid_cdb); end
        end
    endtask

    task automatic test_rst_mid();
        pulse_flush();
        for (int s = 0; s < N_SRC; s++) set_src(s, mk(s, 3));
        tick();
        src_valid = '0;
        tick();
        checks++;
        if (valid_cdb !== 2'b11) begin failures++; $display("FAIL rstmid_pre got=%b exp=11", valid_cdb); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({valid_cdb, Pw_cdb, Result_cdb, exp_cdb, tag_ROB_cdb} !== '0) begin
            failures++; $display("FAIL rstmid_zero got=%b/%h/%h exp=0", valid_cdb, Pw_cdb, Result_cdb);
        end
        tick();
        checks++;
        if (valid_cdb !== 2'b00 || src_ready !== 3'b111) begin
            failures++; $display("FAIL rstmid_after got=%b/%b exp=00/111", valid_cdb, src_ready);
        end
    endtask

    task automatic test_random();
        cdb_entry_t e;
        for (int c = 0; c < 400; c++) begin
            freeze_back = ($urandom_range(0, 9) == 0);
            flush       = ($urandom_range(0, 59) == 0);
            rob_head    = W_TAG'($urandom);
            for (int s = 0; s < N_SRC; s++) begin
                // A blocked source keeps presenting the same entry.
                if (!(src_valid[s] && !src_ready[s])) begin
                    if ($urandom_range(0, 2) != 0) begin
                        e.Pw      = W_P'($urandom);
                        e.result  = W_DATA'($urandom);
                        e.exp     = 1'($urandom);
                        e.tag_ROB = W_TAG'($urandom);
                        set_src(s, e);
                    end else begin
                        src_valid[s] = 1'b0;
                    end
                end
            end
            tick();
            checks++;
            if (src_ready !== model_ready()) begin
                failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, src_ready, model_ready());
            end
            checks++;
            if (valid_cdb !== m_valid) begin
                failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, valid_cdb, m_valid);
            end
            for (int k = 0; k < N_CDB; k++) begin
                if (m_valid[k]) begin
                    checks++;
                    if (bus_entry(k) !== m_bus[k]) begin
                        failures++; $display("FAIL rand_bus%0d cyc=%0d got=%h exp=%h", k, c, bus_entry(k), m_bus[k]);
                    end
                end
            end
        end
        freeze_back = 1'b0;
        flush       = 1'b0;
        src_valid   = '0;
    endtask

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        freeze_back = 1'b0;
        src_valid   = '0;
        src_Pw      = '0;
        src_result  = '0;
        src_exp     = '0;
        src_tag_ROB = '0;
        rob_head    = '0;
        m_valid     = '0;
        m_rr        = 0;
        for (int k = 0; k < N_CDB; k++) m_bus[k] = '0;
        @(negedge clk);

        test_reset();
        test_single_push();
`ifdef CDB_AGE_PRIO_EN
        test_age();
`else
        test_three_sources();
`endif
        test_back_to_back();
        test_freeze();
        test_flush();
        test_rst_mid();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
